// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit bridging the execute stage to a word-addressed memory bus with alignment checks and ack timeout.
module mem_access_unit #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic        busy,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  state_t      state;
  logic        we, uns;
  logic [1:0]  size, err;
  logic [7:0]  cnt;
  logic [31:0] addr, wdata, rdata, lane, ext;
  logic        bad;
  assign bad = (req_size == 2'b11) | (req_size == 2'b01 & req_addr[0]) | (req_size == 2'b10 & |req_addr[1:0]);
  assign lane = mem_rdata >> {addr[1:0], 3'b000};
  assign ext = size == 2'b00 ? {{24{~uns & lane[7]}}, lane[7:0]} :
               size == 2'b01 ? {{16{~uns & lane[15]}}, lane[15:0]} : lane;
  assign req_ready  = state == IDLE;
  assign busy       = state != IDLE;
  assign mem_en     = state == BUS;
  assign resp_valid = state == RESP;
  assign resp_err   = resp_valid ? err : 2'b00;
  assign resp_rdata = resp_valid ? rdata : 32'd0;
  assign mem_addr   = {addr[31:2], 2'b00};
  assign mem_wdata  = size == 2'b00 ? {4{wdata[7:0]}} : size == 2'b01 ? {2{wdata[15:0]}} : wdata;
  assign mem_we     = !(mem_en & we) ? 4'b0000 :
                      size == 2'b00 ? 4'b0001 << addr[1:0] :
                      size == 2'b01 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      we    <= 1'b0;
      uns   <= 1'b0;
      size  <= 2'b00;
      addr  <= 32'd0;
      wdata <= 32'd0;
      rdata <= 32'd0;
      err   <= 2'b00;
      cnt   <= 8'd0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          we    <= req_we;
          uns   <= req_unsigned;
          size  <= req_size;
          addr  <= req_addr;
          wdata <= req_wdata;
          rdata <= 32'd0;
          cnt   <= 8'd0;
          err   <= bad ? 2'b01 : 2'b00;
          state <= bad ? RESP : BUS;
        end
        BUS: if (mem_ack) begin
          rdata <= we ? 32'd0 : ext;
          state <= RESP;
        end else if (cnt == 8'(TIMEOUT_CYC - 1)) begin
          err   <= 2'b10;
          state <= RESP;
        end else begin
          cnt <= cnt + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: TIMEOUT_CYC, 16, max cycles waiting for mem_ack before abort (legal range 1..255).
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  1  access request from execute stage.
REQ-005 req_ready  out  1  high only in IDLE; request accepted on req_valid & req_ready.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 req_unsigned  in  1  load zero-extend (1) or sign-extend (0).
REQ-009 req_addr  in  32  byte address (ALU doutr result).
REQ-010 req_wdata  in  32  store data, right-aligned.
REQ-011 resp_valid  out  1  one-cycle completion pulse.
REQ-012 resp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-013 resp_err  out  2  00 ok, 01 misaligned/illegal size, 10 timeout; valid with resp_valid.
REQ-014 busy  out  1  high whenever state != IDLE (pipeline stall).
REQ-015 mem_en  out  1  memory strobe, held until mem_ack.
REQ-016 mem_we  out  4  byte write enables; 0000 for loads.
REQ-017 mem_addr  out  32  {req_addr[31:2], 2'b00}.
REQ-018 mem_wdata  out  32  lane-replicated store data.
REQ-019 mem_rdata  in  32  read word, valid with mem_ack.
REQ-020 mem_ack  in  1  memory completion, sampled only while mem_en = 1.

Function
REQ-021 FSM states IDLE, BUS, RESP; exactly one state active.
REQ-022 IDLE: on accept, latch we/size/unsigned/addr/wdata; if size = 11, or half with addr[0] = 1, or word with addr[1:0] != 00, go RESP with resp_err = 01 and no mem_en; else go BUS.
REQ-023 BUS: mem_en = 1, mem_addr/mem_we/mem_wdata constant from latched request; mem_ack = 1 -> RESP, capture mem_rdata.
REQ-024 BUS: wait counter starts at 0 on entry, increments each cycle without ack; on the cycle the counter reaches TIMEOUT_CYC-1 with no ack, go RESP with resp_err = 10.
REQ-025 mem_ack in the same cycle as the timeout boundary takes priority: response ok.
REQ-026 RESP: resp_valid = 1 for exactly one cycle, then IDLE; minimum accept-to-resp_valid latency 2 cycles (ack in first BUS cycle).
REQ-027 Byte store: mem_wdata = {4{wdata[7:0]}}, mem_we = 0001 << addr[1:0].
REQ-028 Half store: mem_wdata = {2{wdata[15:0]}}, mem_we = 0011 << (2*addr[1]).
REQ-029 Word store: mem_wdata = wdata, mem_we = 1111.
REQ-030 Loads: lane = mem_rdata >> (8*addr[1:0]); byte/half extended per req_unsigned to 32 bits; word unmodified.
REQ-031 req_valid while busy is ignored; no queueing; req_ready = 0 outside IDLE.
REQ-032 mem_ack outside BUS is ignored.
REQ-033 resp_rdata held at 0 except during resp_valid.

Reset
REQ-034 rst = 1 at any edge: state IDLE, counter 0, all latched fields 0; that edge forces mem_en = 0, mem_we = 0000, resp_valid = 0, resp_err = 00, resp_rdata = 0, busy = 0, req_ready = 1.
REQ-035 Reset in BUS abandons the access with no resp_valid; a subsequent mem_ack is ignored.

Verification
REQ-036 Load byte signed, addr 0x0000_1003, mem_rdata 0x80FF_1234, ack in first BUS cycle -> mem_addr 0x0000_1000, resp_rdata 0xFFFF_FF80, err 00, resp_valid 2 cycles after accept.
REQ-037 Store half, addr 0x0000_0022, wdata 0x1234_ABCD -> mem_we 1100, mem_wdata 0xABCD_ABCD; resp_rdata 0, err 00.
REQ-038 Load word, addr 0x0000_0006 -> no mem_en ever asserted, resp_valid one cycle after accept, err 01.
REQ-039 TIMEOUT_CYC = 4, mem_ack never asserted -> mem_en high 4 cycles, then resp_valid with err 10, return to IDLE.
REQ-040 rst pulsed during second BUS cycle, then mem_ack asserted -> mem_en low after reset edge, no resp_valid, req_ready = 1.
REQ-041 req_valid held high across busy period with new addr -> only first request performed; second accepted only after return to IDLE.
